// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between a hex datapath and the multiplexed 7-segment scan driver.
// The master side drives the value/strobe inputs; the slave side is the driver itself.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load_i;
  logic [4*DIGITS-1:0]   value_i;
  logic [DIGITS-1:0]     dp_i;
  logic [DIGITS-1:0]     blank_i;
  logic [DIGITS-1:0]     blink_en_i;
  logic                  lz_blank_i;
  logic [6:0]            segments_o;
  logic                  seg_dp_o;
  logic [DIGITS-1:0]     digit_en_o;
  logic                  frame_tick_o;

  modport master (
    output load_i, value_i, dp_i, blank_i, blink_en_i, lz_blank_i,
    input  segments_o, seg_dp_o, digit_en_o, frame_tick_o
  );

  modport slave (
    input  load_i, value_i, dp_i, blank_i, blink_en_i, lz_blank_i,
    output segments_o, seg_dp_o, digit_en_o, frame_tick_o
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex 7-segment driver: shadowed value/dp/blank/blink, programmable
// slot rate with dead-time, blinking and leading-zero suppression; all outputs registered.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD           = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic              SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic              DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_INV}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic                   phase_q, phase_d;
  logic [4*DIGITS-1:0]    val_q, val_d;
  logic [DIGITS-1:0]      dp_q, dp_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic [DIGITS-1:0]      blink_q, blink_d;
  logic [6:0]             seg_q, seg_d;
  logic                   sdp_q, sdp_d;
  logic [DIGITS-1:0]      en_q, en_d;
  logic                   ft_q, ft_d;

  logic                   slot_end, frame_end;
  logic [3:0]             nib_arr [DIGITS];
  logic [DIGITS-1:0]      upper_zero;
  logic [3:0]             cur_nib;
  logic                   cur_dp, cur_blank, cur_blink, cur_uz, dark;
  logic [DIGITS-1:0]      onehot;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111011;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // upper_zero[i]: every nibble from digit i up to the most significant one is zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib_arr[gi]    = val_q[4*gi +: 4];
    assign upper_zero[gi] = (val_q[4*DIGITS-1:4*gi] == '0);
  end

  always_comb begin
    slot_end  = (presc_q == PW'(REFRESH_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));

    presc_d = slot_end ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    val_d   = val_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    blink_d = blink_q;
    if (bus.load_i) begin
      val_d   = bus.value_i;
      dp_d    = bus.dp_i;
      blank_d = bus.blank_i;
      blink_d = bus.blink_en_i;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_uz    = 1'b0;
    onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = nib_arr[i];
        cur_dp    = dp_q[i];
        cur_blank = blank_q[i];
        cur_blink = blink_q[i];
        cur_uz    = upper_zero[i];
        onehot[i] = 1'b1;
      end
    end

    // Digit 0 is never leading-zero blanked, so a zero value still shows "0"
    dark = cur_blank || (cur_blink && phase_q) ||
           (bus.lz_blank_i && (idx_q != '0) && cur_uz);

    seg_d = (dark ? 7'b0000000 : hex7(cur_nib)) ^ SEG_OFF;
    sdp_d = (cur_dp && !dark) ^ SEG_INV;
    en_d  = ((presc_q >= PW'(DEAD)) ? onehot : '0) ^ DIG_OFF;
    ft_d  = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      blink_q <= '0;
      seg_q   <= SEG_OFF;
      sdp_q   <= SEG_INV;
      en_q    <= DIG_OFF;
      ft_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      sdp_q   <= sdp_d;
      en_q    <= en_d;
      ft_q    <= ft_d;
    end
  end

  assign bus.segments_o   = seg_q;
  assign bus.seg_dp_o     = sdp_q;
  assign bus.digit_en_o   = en_q;
  assign bus.frame_tick_o = ft_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-high and an active-low instance share one input set
// and are compared every cycle against a timeline model computed from the cycle count.
module tb_seg7_scan_driver;
  localparam int D     = 4;
  localparam int RD    = 4;
  localparam int DT    = 1;
  localparam int BF    = 2;
  localparam int FRAME = RD * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(D)) ifa ();
  seg7_scan_driver_if #(.DIGITS(D)) ifb ();

  assign ifb.load_i     = ifa.load_i;
  assign ifb.value_i    = ifa.value_i;
  assign ifb.dp_i       = ifa.dp_i;
  assign ifb.blank_i    = ifa.blank_i;
  assign ifb.blink_en_i = ifa.blink_en_i;
  assign ifb.lz_blank_i = ifa.lz_blank_i;

  seg7_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(RD), .DEAD(DT), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  seg7_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(RD), .DEAD(DT), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  // Glyphs g..a straight from the encoding table
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71};

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp, sh_blank, sh_blink;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_seg"}, {1'b0, ifa.segments_o}, 8'h00);
    check({tag, "_a_dp"},  {7'b0, ifa.seg_dp_o},   8'h00);
    check({tag, "_a_en"},  {4'b0, ifa.digit_en_o}, 8'h00);
    check({tag, "_a_ft"},  {7'b0, ifa.frame_tick_o}, 8'h00);
    check({tag, "_b_seg"}, {1'b0, ifb.segments_o}, 8'h7F);
    check({tag, "_b_dp"},  {7'b0, ifb.seg_dp_o},   8'h01);
    check({tag, "_b_en"},  {4'b0, ifb.digit_en_o}, 8'h0F);
    check({tag, "_b_ft"},  {7'b0, ifb.frame_tick_o}, 8'h00);
  endtask

  // One clock: derive what the display must show for the current cycle, then compare after the edge
  task automatic step();
    int         slot_pos, idx, frame;
    bit         phase, lz, dark;
    logic [3:0] nib, een;
    logic [6:0] es;
    logic       eds, eft;
    slot_pos = cyc % RD;
    idx      = (cyc / RD) % D;
    frame    = cyc / FRAME;
    phase    = ((frame / BF) % 2) == 1;
    nib      = 4'(sh_val >> (4 * idx));
    lz       = ifa.lz_blank_i && (idx > 0) && ((sh_val >> (4 * idx)) == 16'h0);
    dark     = sh_blank[idx] || (sh_blink[idx] && phase) || lz;
    es       = dark ? 7'h00 : hex_tbl[nib];
    eds      = dark ? 1'b0 : sh_dp[idx];
    een      = (slot_pos >= DT) ? 4'(1 << idx) : 4'h0;
    eft      = ((cyc + 1) % FRAME) == 0;
    if (ifa.load_i) begin
      sh_val   = ifa.value_i;
      sh_dp    = ifa.dp_i;
      sh_blank = ifa.blank_i;
      sh_blink = ifa.blink_en_i;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("a_seg", {1'b0, ifa.segments_o},   {1'b0, es});
    check("a_dp",  {7'b0, ifa.seg_dp_o},     {7'b0, eds});
    check("a_en",  {4'b0, ifa.digit_en_o},   {4'b0, een});
    check("a_ft",  {7'b0, ifa.frame_tick_o}, {7'b0, eft});
    check("b_seg", {1'b0, ifb.segments_o},   {1'b0, ~es});
    check("b_dp",  {7'b0, ifb.seg_dp_o},     {7'b0, ~eds});
    check("b_en",  {4'b0, ifb.digit_en_o},   {4'b0, ~een});
    check("b_ft",  {7'b0, ifb.frame_tick_o}, {7'b0, eft});
    ifa.load_i = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic [3:0] bl);
    ifa.value_i    = v;
    ifa.dp_i       = d;
    ifa.blank_i    = b;
    ifa.blink_en_i = bl;
    ifa.load_i     = 1'b1;
    $display("load cyc=%0d value=%h dp=%b blank=%b blink=%b lz=%0b", cyc, v, d, b, bl,
             ifa.lz_blank_i);
    step();
  endtask

  task automatic model_reset();
    cyc      = 0;
    sh_val   = '0;
    sh_dp    = '0;
    sh_blank = '0;
    sh_blink = '0;
  endtask

  initial begin
    logic [15:0] rv;
    ifa.load_i     = 1'b0;
    ifa.value_i    = '0;
    ifa.dp_i       = '0;
    ifa.blank_i    = '0;
    ifa.blink_en_i = '0;
    ifa.lz_blank_i = 1'b0;
    model_reset();

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Plain scan of 12A0, two frames
    do_load(16'h12A0, 4'h0, 4'h0, 4'h0);
    run(32);

    // Leading-zero suppression on and off
    ifa.lz_blank_i = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0, 4'h0);
    run(16);
    ifa.lz_blank_i = 1'b0;
    run(16);

    // All-zero value: only digit 0 lit, suppressed dp stays dark
    ifa.lz_blank_i = 1'b1;
    do_load(16'h0000, 4'b0100, 4'h0, 4'h0);
    run(16);
    ifa.lz_blank_i = 1'b0;
    do_load(16'h8888, 4'b1010, 4'b0000, 4'b0000);
    run(8);

    // Asynchronous reset while digit 2 is displayed
    while ((cyc % FRAME) != 10) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midslot");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(16);

    // Blink digit 0 across six frames
    do_load(16'h12A0, 4'b0001, 4'h0, 4'b0001);
    run(96);

    // Load on the last cycle of a frame
    while ((cyc % FRAME) != FRAME - 1) step();
    do_load(16'hF3E7, 4'b1001, 4'b0100, 4'h0);
    run(8);

    // Randomised loads and live lz_blank
    for (int i = 0; i < 240; i++) begin
      if ($urandom_range(0, 3) == 0) ifa.lz_blank_i = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) begin
        rv = 16'($urandom);
        if ($urandom_range(0, 1) == 1) rv = rv >> (4 * $urandom_range(1, 3));
        do_load(rv, 4'($urandom), 4'($urandom & $urandom & $urandom),
                4'($urandom & $urandom));
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
